tom_bus_arbiter: RTL and testbench



---
 rtl/tom_bus_arbiter_if.sv | 25 ++
 rtl/tom_bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_tom_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tom_bus_arbiter_if.sv
// Bus-ownership handshake between Tom's bus masters and the bus arbiter.
// The master side drives the requests and memory strobes. The slave side (the
// arbiter) returns the one-hot acknowledges, the owner code and the idle flag.
interface tom_bus_arbiter_if;
    logic       dma_breq;
    logic [1:0] blit_breq;
    logic       gpu_breq;
    logic       lock;
    logic       ack;
    logic       dma_back;
    logic       blit_back;
    logic       gpu_back;
    logic [1:0] owner;
    logic       bus_idle;

    modport master (
        output dma_breq, blit_breq, gpu_breq, lock, ack,
        input  dma_back, blit_back, gpu_back, owner, bus_idle
    );

    modport slave (
        input  dma_breq, blit_breq, gpu_breq, lock, ack,
        output dma_back, blit_back, gpu_back, owner, bus_idle
    );
endinterface

// File: rtl/tom_bus_arbiter.sv
// Tom shared external bus arbiter.
// Three masters compete for the bus: DMA, blitter and GPU. DMA has the highest
// priority, followed by a high-priority blitter request. The GPU and a
// normal-priority blitter request share the lowest class and are served in
// round-robin order. An owner gives up the bus when it drops its request, or at
// a memory-cycle boundary (ack) when it is preempted. Preemption happens when
// DMA wants the bus, or when the owner has used up its burst allowance and a
// competitor is waiting. Lock suppresses preemption. Every release is followed
// by a fixed turnaround window before the next grant.
module tom_bus_arbiter #(
    parameter int unsigned MAX_BURST       = 8,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned HANDOVER_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    tom_bus_arbiter_if.slave  bus
);

    // Owner codes, as seen on the owner output.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DMA  = 2'd1;
    localparam logic [1:0] OWN_BLIT = 2'd2;
    localparam logic [1:0] OWN_GPU  = 2'd3;

    // The burst comparison is one bit wider so that count+1 cannot wrap.
    localparam logic [CNT_W:0]   BURST_LIMIT = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_BURST);
    localparam logic [1:0]       HO_LAST     = 2'(HANDOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN      = 2'd1,
        ST_HANDOVER = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rr_gpu_first;
    logic             w_rr_nxt;
    logic [1:0]       r_ho_cnt;
    logic [1:0]       w_ho_nxt;

    logic             r_dma_back;
    logic             r_blit_back;
    logic             r_gpu_back;
    logic             r_bus_idle;
    logic             w_dma_back_nxt;
    logic             w_blit_back_nxt;
    logic             w_gpu_back_nxt;
    logic             w_bus_idle_nxt;

    logic             w_own_req;
    logic             w_competitor;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             w_burst_hit;
    logic             w_preempt;
    logic [1:0]       w_grant_owner;
    logic             w_grant_rr;

    // The count is at most MAX_BURST, so count+1 is at most MAX_BURST+1. The
    // extra bit of w_cnt_inc keeps that value from wrapping.
    assign w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_burst_hit = (w_cnt_inc >= BURST_LIMIT);
    assign w_cnt_sat   = w_burst_hit ? CNT_SAT : w_cnt_inc[CNT_W-1:0];

    // Live request of the current owner, and whether a competitor of its class is pending.
    always_comb begin
        w_own_req    = 1'b0;
        w_competitor = 1'b0;
        case (r_owner)
            OWN_DMA: begin
                w_own_req    = bus.dma_breq;
                w_competitor = 1'b0;
            end
            OWN_BLIT: begin
                w_own_req = |bus.blit_breq;
                // The blitter's class follows blit_breq[1] live.
                if (bus.blit_breq[1]) begin
                    w_competitor = bus.dma_breq;
                end else begin
                    w_competitor = bus.dma_breq | bus.gpu_breq;
                end
            end
            OWN_GPU: begin
                w_own_req    = bus.gpu_breq;
                w_competitor = bus.dma_breq | (|bus.blit_breq);
            end
            default: begin
                w_own_req    = 1'b0;
                w_competitor = 1'b0;
            end
        endcase
    end

    // Preemption is only considered at an unlocked memory-cycle boundary.
    assign w_preempt = bus.ack & ~bus.lock &
                       ((bus.dma_breq & (r_owner != OWN_DMA)) | (w_burst_hit & w_competitor));

    // Fixed-priority choice in IDLE, with round-robin inside the GPU / normal-blitter pair.
    always_comb begin
        w_grant_owner = OWN_NONE;
        w_grant_rr    = 1'b0;
        if (bus.dma_breq) begin
            w_grant_owner = OWN_DMA;
        end else if (bus.blit_breq[1]) begin
            w_grant_owner = OWN_BLIT;
        end else if (bus.gpu_breq && bus.blit_breq[0]) begin
            w_grant_owner = r_rr_gpu_first ? OWN_GPU : OWN_BLIT;
            w_grant_rr    = 1'b1;
        end else if (bus.gpu_breq) begin
            w_grant_owner = OWN_GPU;
            w_grant_rr    = 1'b1;
        end else if (bus.blit_breq[0]) begin
            w_grant_owner = OWN_BLIT;
            w_grant_rr    = 1'b1;
        end else begin
            w_grant_owner = OWN_NONE;
            w_grant_rr    = 1'b0;
        end
    end

    // State register: FSM state, owner, burst count, round-robin pointer and handover count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_NONE;
            r_cnt          <= {CNT_W{1'b0}};
            r_rr_gpu_first <= 1'b1;
            r_ho_cnt       <= 2'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_owner        <= w_owner_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rr_gpu_first <= w_rr_nxt;
            r_ho_cnt       <= w_ho_nxt;
        end
    end

    // Next-state logic: grant from IDLE, release or burst counting in OWN, turnaround in HANDOVER.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_gpu_first;
        w_ho_nxt    = r_ho_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_owner != OWN_NONE) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_grant_owner;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_rr_nxt    = w_grant_rr ? ~r_rr_gpu_first : r_rr_gpu_first;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWN_NONE;
                end
            end
            ST_OWN: begin
                // A request drop wins over everything, including lock and a coincident ack.
                if (!w_own_req || w_preempt) begin
                    w_state_nxt = ST_HANDOVER;
                    w_owner_nxt = OWN_NONE;
                    w_ho_nxt    = 2'd0;
                end else if (bus.ack) begin
                    w_cnt_nxt = w_cnt_sat;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_HANDOVER: begin
                w_owner_nxt = OWN_NONE;
                if (r_ho_cnt == HO_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ho_nxt    = 2'd0;
                end else begin
                    w_ho_nxt = r_ho_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWN_NONE;
                w_ho_nxt    = 2'd0;
            end
        endcase
    end

    // Output decode: one-hot acknowledges from the next owner, and the idle flag.
    always_comb begin
        w_dma_back_nxt  = (w_owner_nxt == OWN_DMA);
        w_blit_back_nxt = (w_owner_nxt == OWN_BLIT);
        w_gpu_back_nxt  = (w_owner_nxt == OWN_GPU);
        // Idle means IDLE now and staying there, so bus_idle never overlaps a granted cycle.
        if ((r_state == ST_IDLE) && (w_state_nxt == ST_IDLE)) begin
            w_bus_idle_nxt = 1'b1;
        end else begin
            w_bus_idle_nxt = 1'b0;
        end
    end

    // Output registers: the acknowledges drive tri-state enables, so they must be glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dma_back  <= 1'b0;
            r_blit_back <= 1'b0;
            r_gpu_back  <= 1'b0;
            r_bus_idle  <= 1'b1;
        end else begin
            r_dma_back  <= w_dma_back_nxt;
            r_blit_back <= w_blit_back_nxt;
            r_gpu_back  <= w_gpu_back_nxt;
            r_bus_idle  <= w_bus_idle_nxt;
        end
    end

    assign bus.dma_back  = r_dma_back;
    assign bus.blit_back = r_blit_back;
    assign bus.gpu_back  = r_gpu_back;
    assign bus.owner     = r_owner;
    assign bus.bus_idle  = r_bus_idle;

endmodule

// File: tb/tb_tom_bus_arbiter.sv
// Self-checking bench for tom_bus_arbiter. It runs three kinds of test:
//  - A table of hand-derived vectors.
//  - Hand-written sequences for burst, lock, class-change and reset corners.
//  - Randomized traffic checked against a transaction-level reference model.
module tb_tom_bus_arbiter;

    localparam int MB = 4;
    localparam int HC = 1;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    tom_bus_arbiter_if bus();

    tom_bus_arbiter #(
        .MAX_BURST(MB),
        .CNT_W(4),
        .HANDOVER_CYCLES(HC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        bit       dma;
        bit [1:0] blit;
        bit       gpu;
        bit       lock;
        bit       ack;
        int       exp_owner;
        bit       exp_idle;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model (transaction level) ----------------
    int m_owner;
    int m_ho_left;
    int m_acks;
    bit m_gpu_first;
    bit m_bus_idle;

    task automatic model_reset();
        m_owner     = 0;
        m_ho_left   = 0;
        m_acks      = 0;
        m_gpu_first = 1'b1;
        m_bus_idle  = 1'b1;
    endtask

    task automatic model_step(input bit dma, input bit [1:0] blit, input bit gpu,
                              input bit lock, input bit ack);
        bit was_idle;
        bit req;
        bit rival;
        was_idle = (m_owner == 0) && (m_ho_left == 0);
        if (m_ho_left > 0) begin
            m_ho_left--;
        end else if (m_owner == 0) begin
            if (dma) m_owner = 1;
            else if (blit[1]) m_owner = 2;
            else if (gpu || blit[0]) begin
                if (gpu && blit[0]) m_owner = m_gpu_first ? 3 : 2;
                else m_owner = gpu ? 3 : 2;
                m_gpu_first = !m_gpu_first;
            end
            m_acks = 0;
        end else begin
            req   = (m_owner == 1) ? dma : (m_owner == 2) ? (blit != 2'b00) : gpu;
            rival = (m_owner == 1) ? 1'b0 :
                    (m_owner == 2) ? (blit[1] ? dma : (dma || gpu)) :
                                     (dma || (blit != 2'b00));
            if (!req || (ack && !lock && ((dma && m_owner != 1) || ((m_acks + 1 >= MB) && rival)))) begin
                m_owner   = 0;
                m_ho_left = HC;
            end else if (ack && m_acks < MB) begin
                m_acks++;
            end
        end
        m_bus_idle = was_idle && (m_owner == 0) && (m_ho_left == 0);
    endtask

    // ---------------- helpers ----------------
    function automatic int obs();
        int r;
        r = 0;
        r[5:0] = {bus.dma_back, bus.blit_back, bus.gpu_back, bus.owner, bus.bus_idle};
        return r;
    endfunction

    function automatic int expv(input int own, input bit idle);
        int r;
        r = 0;
        r[5]   = (own == 1);
        r[4]   = (own == 2);
        r[3]   = (own == 3);
        r[2:1] = own[1:0];
        r[0]   = idle;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit d, input bit [1:0] b, input bit g, input bit l, input bit a);
        bus.dma_breq  = d;
        bus.blit_breq = b;
        bus.gpu_breq  = g;
        bus.lock      = l;
        bus.ack       = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit d, input bit [1:0] b, input bit g, input bit l, input bit a,
                       input int own, input bit idle);
        vec_t v;
        v.dma = d; v.blit = b; v.gpu = g; v.lock = l; v.ack = a;
        v.exp_owner = own; v.exp_idle = idle;
        tbl.push_back(v);
    endtask

    initial begin
        int cur;
        int nxt;
        int tenures;
        int acks;
        int exp_grant;
        bit ackb;
        bit d;
        bit g;
        bit l;
        bit a;
        bit [1:0] b;

        // Vectors: inputs are sampled at the next edge; the expected values are the outputs after that edge.
        add(0, 2'b00, 0, 0, 0, 0, 1); // 0  idle after reset
        add(0, 2'b00, 1, 0, 0, 3, 0); // 1  GPU granted one edge later
        add(0, 2'b00, 1, 0, 0, 3, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0); // 3  voluntary release
        add(0, 2'b00, 0, 0, 0, 0, 0); // 4  handover -> idle
        add(0, 2'b00, 0, 0, 0, 0, 1); // 5  bus_idle rises
        add(1, 2'b10, 1, 0, 0, 1, 0); // 6  DMA wins
        add(1, 2'b10, 1, 0, 0, 1, 0);
        add(0, 2'b10, 1, 0, 0, 0, 0); // 8  DMA drops
        add(0, 2'b10, 1, 0, 0, 0, 0);
        add(0, 2'b10, 1, 0, 0, 2, 0); // 10 high blitter next
        add(0, 2'b10, 1, 0, 0, 2, 0);
        add(0, 2'b00, 1, 0, 0, 0, 0); // 12 blitter drops
        add(0, 2'b00, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 3, 0); // 14 GPU last
        add(0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1);
        add(0, 2'b00, 1, 0, 0, 3, 0); // 18 GPU owns
        add(1, 2'b00, 1, 0, 0, 3, 0); // 19 DMA waits: no ack
        add(1, 2'b00, 1, 1, 1, 3, 0); // 20 locked ack
        add(1, 2'b00, 1, 0, 1, 0, 0); // 21 DMA preempts
        add(1, 2'b00, 1, 0, 0, 0, 0);
        add(1, 2'b00, 1, 0, 0, 1, 0); // 23 DMA granted
        add(1, 2'b00, 1, 0, 1, 1, 0); // 24 DMA never preempted
        add(0, 2'b00, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 3, 0); // 27 GPU again
        add(0, 2'b00, 0, 0, 1, 0, 0); // 28 drop + ack together
        add(0, 2'b00, 0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1);

        // Reset state.
        reset_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0);
        repeat (3) step();
        check("reset_state", obs(), expv(0, 1'b1));
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].dma, tbl[i].blit, tbl[i].gpu, tbl[i].lock, tbl[i].ack);
            step();
            check($sformatf("vec%0d", i), obs(), expv(tbl[i].exp_owner, tbl[i].exp_idle));
        end

        // Round robin: GPU and normal blitter held, ack every 2nd cycle, MAX_BURST acks per tenure.
        drive(0, 2'b01, 1, 0, 0);
        tenures   = 0;
        acks      = 0;
        ackb      = 1'b0;
        exp_grant = 3;
        for (int c = 0; c < 300 && tenures < 6; c++) begin
            ackb     = ~ackb;
            bus.ack  = ackb;
            cur      = int'(bus.owner);
            step();
            nxt = int'(bus.owner);
            if (cur != 0 && ackb) acks++;
            if (cur == 0 && nxt != 0) begin
                check("rr_grant", nxt, exp_grant);
                exp_grant = (exp_grant == 3) ? 2 : 3;
                acks = 0;
            end
            if (cur != 0 && nxt == 0) begin
                check("rr_burst_len", acks, MB);
                tenures++;
            end
        end
        check("rr_tenures", tenures, 6);
        drive(0, 2'b00, 0, 0, 0);
        repeat (3) step();
        check("rr_idle", obs(), expv(0, 1'b1));

        // Lock holds off DMA across 10 acks; release on the first unlocked ack.
        drive(0, 2'b00, 1, 0, 0);
        step();
        check("lock_gpu_grant", obs(), expv(3, 1'b0));
        drive(1, 2'b00, 1, 1, 0);
        for (int c = 0; c < 20; c++) begin
            bus.ack = (c % 2 == 0);
            step();
            check($sformatf("lock_hold%0d", c), int'(bus.gpu_back), 1);
        end
        drive(1, 2'b00, 1, 0, 1);
        step();
        check("lock_release", obs(), expv(0, 1'b0));
        bus.ack = 1'b0;
        step();
        check("lock_gap", obs(), expv(0, 1'b0));
        step();
        check("lock_dma_grant", obs(), expv(1, 1'b0));
        drive(0, 2'b00, 0, 0, 0);
        repeat (3) step();
        check("lock_idle", obs(), expv(0, 1'b1));

        // High-priority blitter is immune to a pending GPU; dropping to normal class gets it preempted.
        drive(0, 2'b10, 1, 0, 0);
        step();
        check("cls_grant", obs(), expv(2, 1'b0));
        bus.ack = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            check($sformatf("cls_hold%0d", c), int'(bus.owner), 2);
        end
        drive(0, 2'b01, 1, 0, 1);
        step();
        check("cls_preempt", obs(), expv(0, 1'b0));
        drive(0, 2'b00, 0, 0, 0);
        repeat (3) step();
        check("cls_idle", obs(), expv(0, 1'b1));

        // Asynchronous reset in the middle of a DMA tenure.
        drive(1, 2'b00, 0, 0, 0);
        step();
        check("rst_dma_grant", obs(), expv(1, 1'b0));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_clear", obs(), expv(0, 1'b1));
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("rst_regrant", obs(), expv(1, 1'b0));
        drive(0, 2'b00, 0, 0, 0);
        repeat (3) step();

        // Randomized traffic against the reference model.
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        d = 1'b0; b = 2'b00; g = 1'b0; l = 1'b0; a = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) d = ~d;
            if ($urandom_range(7) == 0) b[1] = ~b[1];
            if ($urandom_range(7) == 0) b[0] = ~b[0];
            if ($urandom_range(7) == 0) g = ~g;
            if ($urandom_range(5) == 0) l = ~l;
            a = 1'($urandom_range(1));
            drive(d, b, g, l, a);
            step();
            model_step(d, b, g, l, a);
            check($sformatf("rand%0d", c), obs(), expv(m_owner, m_bus_idle));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
